// File: rtl/msg_pingpong_select_buffer.sv
// Ping-pong message block store: one bank fills column by column while the other
// serves CH independent column reads with a registered, zero-filled output.
module msg_pingpong_select_buffer #(
    parameter int ZC_W  = 384,
    parameter int COLS  = 22,
    parameter int CH    = 4,
    parameter int COL_W = $clog2(COLS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [COL_W:0]        kb,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ZC_W-1:0]       wr_data,
    input  logic                  rd_en,
    input  logic [CH*COL_W-1:0]   rd_col,
    input  logic                  rd_done,
    output logic                  rd_bank_full,
    output logic [COL_W:0]        rd_kb,
    output logic [CH*ZC_W-1:0]    rd_data,
    output logic                  rd_data_vld,
    output logic [1:0]            occupancy
);

    typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_t;

    localparam logic [COL_W:0] KB_MAX = (COL_W+1)'(COLS);
    localparam logic [COL_W:0] KB_ONE = (COL_W+1)'(1);

    bank_state_t           bank_state_reg [2];
    logic [COL_W:0]        bank_kb_reg    [2];
    logic                  wr_bank_reg;
    logic                  rd_bank_reg;
    logic [COL_W-1:0]      wr_col_reg;
    logic [ZC_W-1:0]       mem [2][COLS];
    logic [CH*ZC_W-1:0]    rd_data_reg;
    logic                  rd_data_vld_reg;

    logic [COL_W:0]        kb_clamped;
    logic [COL_W:0]        wr_kb;
    logic                  wr_last;
    logic                  wr_fire;
    logic                  rd_release;
    logic [CH*ZC_W-1:0]    rd_sel;

    assign kb_clamped   = (kb == '0 || kb > KB_MAX) ? KB_MAX : kb;
    // kb is only taken from the port on the first write of a bank
    assign wr_kb        = (bank_state_reg[wr_bank_reg] == BANK_EMPTY) ? kb_clamped
                                                                      : bank_kb_reg[wr_bank_reg];
    assign wr_last      = ({1'b0, wr_col_reg} + KB_ONE) == wr_kb;
    assign wr_ready     = bank_state_reg[wr_bank_reg] != BANK_FULL;
    assign wr_fire      = wr_valid & wr_ready & ~flush;
    assign rd_bank_full = bank_state_reg[rd_bank_reg] == BANK_FULL;
    assign rd_release   = rd_done & rd_bank_full;
    assign rd_kb        = rd_bank_full ? bank_kb_reg[rd_bank_reg] : '0;
    assign occupancy    = {1'b0, bank_state_reg[0] == BANK_FULL}
                        + {1'b0, bank_state_reg[1] == BANK_FULL};
    assign rd_data      = rd_data_reg;
    assign rd_data_vld  = rd_data_vld_reg;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank_reg][wr_col_reg] <= wr_data;
        end
    end

    // Columns at or beyond the stored kb read as zero; rd_kb is 0 for a non-full bank
    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [COL_W-1:0] col;
            assign col = rd_col[gi*COL_W +: COL_W];
            assign rd_sel[gi*ZC_W +: ZC_W] = ({1'b0, col} < rd_kb) ? mem[rd_bank_reg][col] : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                bank_state_reg[b] <= BANK_EMPTY;
                bank_kb_reg[b]    <= '0;
            end
            wr_bank_reg     <= 1'b0;
            rd_bank_reg     <= 1'b0;
            wr_col_reg      <= '0;
            rd_data_reg     <= '0;
            rd_data_vld_reg <= 1'b0;
        end else if (flush) begin
            for (int b = 0; b < 2; b++) begin
                bank_state_reg[b] <= BANK_EMPTY;
                bank_kb_reg[b]    <= '0;
            end
            wr_bank_reg     <= 1'b0;
            rd_bank_reg     <= 1'b0;
            wr_col_reg      <= '0;
            rd_data_reg     <= '0;
            rd_data_vld_reg <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_data_reg     <= rd_sel;
                rd_data_vld_reg <= rd_bank_full;
            end else begin
                rd_data_vld_reg <= 1'b0;
            end
            // A write never targets a FULL bank, so write and release cannot hit the same bank
            if (wr_fire) begin
                if (bank_state_reg[wr_bank_reg] == BANK_EMPTY) begin
                    bank_kb_reg[wr_bank_reg] <= kb_clamped;
                end
                bank_state_reg[wr_bank_reg] <= wr_last ? BANK_FULL : BANK_FILLING;
                if (wr_last) begin
                    wr_col_reg  <= '0;
                    wr_bank_reg <= ~wr_bank_reg;
                end else begin
                    wr_col_reg  <= wr_col_reg + 1'b1;
                end
            end
            if (rd_release) begin
                bank_state_reg[rd_bank_reg] <= BANK_EMPTY;
                rd_bank_reg                 <= ~rd_bank_reg;
            end
        end
    end

endmodule

// File: tb/tb_msg_pingpong_select_buffer.sv
// Directed and randomized checks of the ping-pong buffer against a FIFO-of-codewords model.
module tb_msg_pingpong_select_buffer;

    localparam int ZC_W  = 384;
    localparam int COLS  = 22;
    localparam int CH    = 4;
    localparam int COL_W = 5;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 flush;
    logic [COL_W:0]       kb;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [ZC_W-1:0]      wr_data;
    logic                 rd_en;
    logic [CH*COL_W-1:0]  rd_col;
    logic                 rd_done;
    logic                 rd_bank_full;
    logic [COL_W:0]       rd_kb;
    logic [CH*ZC_W-1:0]   rd_data;
    logic                 rd_data_vld;
    logic [1:0]           occupancy;

    always #5 clk = ~clk;

    msg_pingpong_select_buffer #(.ZC_W(ZC_W), .COLS(COLS), .CH(CH)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .kb(kb),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_en(rd_en), .rd_col(rd_col), .rd_done(rd_done),
        .rd_bank_full(rd_bank_full), .rd_kb(rd_kb), .rd_data(rd_data),
        .rd_data_vld(rd_data_vld), .occupancy(occupancy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: completed codewords queue up in order (at most two), front one is readable
    logic [ZC_W-1:0] fq_data [2][COLS];
    int              fq_kb   [2];
    int              fq_n;
    logic [ZC_W-1:0] cur_buf [COLS];
    int              cur_kb;
    int              cur_n;
    logic [ZC_W-1:0] exp_data [CH];
    logic            exp_vld;

    task automatic check_val(input string tag, input logic [ZC_W-1:0] got, input logic [ZC_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [ZC_W-1:0] rd_ch(input int c);
        return rd_data[c*ZC_W +: ZC_W];
    endfunction

    function automatic int clamp_kb(input int k);
        return (k == 0 || k > COLS) ? COLS : k;
    endfunction

    function automatic logic [ZC_W-1:0] rand_blk();
        logic [ZC_W-1:0] r;
        for (int i = 0; i < ZC_W/32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic model_clear();
        fq_n    = 0;
        cur_n   = 0;
        exp_vld = 1'b0;
        for (int c = 0; c < CH; c++) exp_data[c] = '0;
    endtask

    task automatic model_step();
        bit rel, done_cw;
        int col;
        if (flush) begin
            model_clear();
            return;
        end
        if (rd_en) begin
            for (int c = 0; c < CH; c++) begin
                col = int'(rd_col[c*COL_W +: COL_W]);
                exp_data[c] = (fq_n > 0 && col < fq_kb[0]) ? fq_data[0][col] : '0;
            end
            exp_vld = (fq_n > 0);
        end else begin
            exp_vld = 1'b0;
        end
        rel     = rd_done && fq_n > 0;
        done_cw = 0;
        if (wr_valid && fq_n < 2) begin
            if (cur_n == 0) cur_kb = clamp_kb(int'(kb));
            cur_buf[cur_n] = wr_data;
            cur_n++;
            if (cur_n == cur_kb) done_cw = 1;
        end
        if (rel) begin
            for (int i = 0; i < COLS; i++) fq_data[0][i] = fq_data[1][i];
            fq_kb[0] = fq_kb[1];
            fq_n--;
        end
        if (done_cw) begin
            for (int i = 0; i < COLS; i++) fq_data[fq_n][i] = cur_buf[i];
            fq_kb[fq_n] = cur_kb;
            fq_n++;
            cur_n = 0;
        end
    endtask

    task automatic check_outputs();
        check_val("wr_ready",     ZC_W'(wr_ready),     ZC_W'(fq_n < 2));
        check_val("occupancy",    ZC_W'(occupancy),    ZC_W'(fq_n));
        check_val("rd_bank_full", ZC_W'(rd_bank_full), ZC_W'(fq_n > 0));
        check_val("rd_kb",        ZC_W'(rd_kb),        ZC_W'(fq_n > 0 ? fq_kb[0] : 0));
        check_val("rd_data_vld",  ZC_W'(rd_data_vld),  ZC_W'(exp_vld));
        for (int c = 0; c < CH; c++) check_val($sformatf("rd_data[%0d]", c), rd_ch(c), exp_data[c]);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_idle();
        flush = 0; kb = '0; wr_valid = 0; wr_data = '0;
        rd_en = 0; rd_col = '0; rd_done = 0;
    endtask

    task automatic fill(input int kbv, input int ncols, input bit rdone_last);
        for (int i = 0; i < ncols; i++) begin
            wr_valid = 1;
            kb       = (COL_W+1)'(kbv);
            wr_data  = ZC_W'(i + 1);
            rd_done  = rdone_last && (i == ncols - 1);
            cycle();
        end
        wr_valid = 0;
        rd_done  = 0;
        $display("fill kb=%0d cols=%0d occupancy=%0d rd_kb=%0d", kbv, ncols, occupancy, rd_kb);
    endtask

    task automatic read_cols(input int a, input int b, input int c, input int d);
        rd_en  = 1;
        rd_col = {COL_W'(d), COL_W'(c), COL_W'(b), COL_W'(a)};
        cycle();
        rd_en  = 0;
        $display("read cols=%0d,%0d,%0d,%0d vld=%0b", a, b, c, d, rd_data_vld);
    endtask

    task automatic done_pulse();
        rd_done = 1;
        cycle();
        rd_done = 0;
        $display("rd_done occupancy=%0d", occupancy);
    endtask

    initial begin
        reset_n = 0;
        set_idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset_n = 1;

        // BG1 fill and arbitrary column read
        fill(22, 22, 0);
        check_val("bg1_full", ZC_W'(rd_bank_full), ZC_W'(1));
        check_val("bg1_kb",   ZC_W'(rd_kb),        ZC_W'(22));
        read_cols(3, 0, 21, 7);
        check_val("bg1_c0", rd_ch(0), ZC_W'(4));
        check_val("bg1_c1", rd_ch(1), ZC_W'(1));
        check_val("bg1_c2", rd_ch(2), ZC_W'(22));
        check_val("bg1_c3", rd_ch(3), ZC_W'(8));
        check_val("bg1_vld", ZC_W'(rd_data_vld), ZC_W'(1));

        // Second bank fills while first is held: both full
        fill(10, 10, 0);
        check_val("pp_occ2",   ZC_W'(occupancy), ZC_W'(2));
        check_val("pp_wrrdy0", ZC_W'(wr_ready),  ZC_W'(0));
        done_pulse();
        check_val("pp_occ1",   ZC_W'(occupancy), ZC_W'(1));
        check_val("pp_wrrdy1", ZC_W'(wr_ready),  ZC_W'(1));
        check_val("bg2_kb",    ZC_W'(rd_kb),     ZC_W'(10));
        read_cols(9, 10, 15, 0);
        check_val("bg2_c0", rd_ch(0), ZC_W'(10));
        check_val("bg2_c1", rd_ch(1), ZC_W'(0));
        check_val("bg2_c2", rd_ch(2), ZC_W'(0));
        check_val("bg2_c3", rd_ch(3), ZC_W'(1));

        // Last write of one bank coincides with release of the other
        fill(30, 22, 1);
        check_val("sim_occ", ZC_W'(occupancy), ZC_W'(1));
        check_val("kb30_kb", ZC_W'(rd_kb),     ZC_W'(22));
        done_pulse();

        // Empty read and spurious release
        read_cols(0, 1, 2, 3);
        check_val("empty_vld", ZC_W'(rd_data_vld), ZC_W'(0));
        check_val("empty_c0",  rd_ch(0),           ZC_W'(0));
        done_pulse();
        check_val("spur_occ",  ZC_W'(occupancy),   ZC_W'(0));

        fill(0, 22, 0);
        check_val("kb0_kb", ZC_W'(rd_kb), ZC_W'(22));

        // Async reset mid-fill while rd_data_vld is high
        rd_en  = 1;
        rd_col = {COL_W'(1), COL_W'(2), COL_W'(3), COL_W'(4)};
        fill(22, 5, 0);
        check_val("pre_rst_vld", ZC_W'(rd_data_vld), ZC_W'(1));
        #2;
        reset_n = 0;
        model_clear();
        #1;
        check_val("rst_vld", ZC_W'(rd_data_vld), ZC_W'(0));
        check_val("rst_occ", ZC_W'(occupancy),   ZC_W'(0));
        check_outputs();
        rd_en = 0;
        @(negedge clk);
        reset_n = 1;

        // Flush mid-fill, then a short codeword must start from column 0
        fill(22, 5, 0);
        flush = 1;
        cycle();
        flush = 0;
        check_val("flush_occ", ZC_W'(occupancy), ZC_W'(0));
        fill(3, 3, 0);
        read_cols(0, 1, 2, 5);
        check_val("post_flush_c2", rd_ch(2), ZC_W'(3));
        done_pulse();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            kb       = (COL_W+1)'($urandom_range(0, 31));
            wr_data  = rand_blk();
            rd_en    = ($urandom_range(0, 1) != 0);
            rd_col   = (CH*COL_W)'($urandom());
            rd_done  = ($urandom_range(0, 15) == 0);
            flush    = ($urandom_range(0, 499) == 0);
            cycle();
        end
        set_idle();
        $display("random phase done occupancy=%0d", occupancy);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
